switch_event_gen: RTL
=====================

# switch_event_gen

Front-end conditioning stage for one push-button, sitting directly upstream of the per-switch counters and the binary-to-7-segment converters on the Go Board (25 MHz). It synchronises the raw pin, debounces it, and emits single-cycle press, release and auto-repeat event pulses. Counter logic consumes the events directly and needs no local edge-detect register. One instance per switch.

## Interface
- DEBOUNCE_LIMIT, 250000: consecutive stable cycles required to accept a level change (10 ms at 25 MHz); must be ≥2.
- REPEAT_DELAY, 12500000: cycles from press to first repeat (500 ms); must be ≥2.
- REPEAT_RATE, 2500000: cycles between subsequent repeats (100 ms); must be ≥2.
- i_Clk  input  1  system clock; single clock domain.
- i_Rst  input  1  reset; synchronous, active-high.
- i_Switch  input  1  raw switch pin, asynchronous; 1 = pressed.
- o_Level  output  1  debounced switch level.
- o_Press  output  1  one-cycle pulse on accepted 0→1.
- o_Release  output  1  one-cycle pulse on accepted 1→0.
- o_Repeat  output  1  one-cycle auto-repeat pulse while held.

## Operation
- Synchroniser: two flops, r_Sync1 → r_Sync2, both reset to 0.
- Debounce: counter sized $clog2(DEBOUNCE_LIMIT). If r_Sync2 == r_Stable, counter clears to 0. If they differ and the counter is DEBOUNCE_LIMIT-1, r_Stable takes r_Sync2 and the counter clears. Otherwise the counter increments. Any return to the stable value before the limit discards the count, so glitches shorter than DEBOUNCE_LIMIT cycles have no effect.
- o_Level = r_Stable.
- o_Press and o_Release are registered. They assert on the same edge o_Level changes and clear on the next edge.
- Repeat FSM states: IDLE, HELD_DELAY, HELD_REPEAT. The repeat timer is sized $clog2(max(REPEAT_DELAY, REPEAT_RATE)).
  - IDLE → HELD_DELAY on accepted rise; timer cleared.
  - HELD_DELAY: timer increments. At REPEAT_DELAY-1: pulse o_Repeat, clear timer, go to HELD_REPEAT.
  - HELD_REPEAT: timer increments. At REPEAT_RATE-1: pulse o_Repeat, clear timer.
  - Accepted fall in either HELD state → IDLE; timer cleared.
- Simultaneous events: if an accepted fall coincides with a repeat terminal count, o_Release asserts and o_Repeat does not. o_Press and o_Repeat never assert together.
- Reset values: o_Level, o_Press, o_Release and o_Repeat = 0; state IDLE; all counters 0.
- Reset mid-operation: returns to IDLE immediately with no release pulse. A switch still held after reset re-qualifies through the full debounce and produces a fresh o_Press.

## Timing
- Let edge k be the first i_Clk edge that samples the new i_Switch value, with the value held thereafter. o_Level, o_Press and o_Release update at edge k+DEBOUNCE_LIMIT+1.
- For an o_Press at edge P: the first o_Repeat is at P+REPEAT_DELAY, then every REPEAT_RATE edges after that, until the release edge.
- All outputs are registered, with no combinational path from i_Switch.
- Pulse width is exactly one i_Clk cycle.

## Configuration
- SWITCH_AUTO_REPEAT_EN defined: repeat FSM and timer are built, and o_Repeat behaves as above.
- SWITCH_AUTO_REPEAT_EN undefined: FSM and timer are omitted and o_Repeat is tied to 0. REPEAT_DELAY and REPEAT_RATE are ignored. Level, press and release behaviour is unchanged.

## Structure
- Package switch_event_pkg contains:
  - the state enum (IDLE, HELD_DELAY, HELD_REPEAT);
  - a counter-width helper function;
  - default timing constants for 25 MHz (10 ms, 500 ms, 100 ms in cycles).
- Sub-module switch_debounce_core holds the synchroniser and debounce counter, with outputs r_Stable plus rise/fall strobes. switch_event_gen adds the pulse registers and the repeat FSM.

## Test plan
Bench parameters: DEBOUNCE_LIMIT=4, REPEAT_DELAY=10, REPEAT_RATE=3, macro defined.
- Clean press, first sampled at edge 0 and held → o_Level=1 and o_Press pulse at edge 5. No other pulse before edge 15.
- Hold continued, release first sampled at edge 30 → o_Repeat at edges 15, 18, 21, 24, 27, 30, 33 (7 pulses); o_Release and o_Level=0 at edge 35.
- Glitch high for 3 cycles, then low → o_Level stays 0; no pulses.
- Chatter 1-0-1-0 every 2 cycles, then steady 1 → exactly one o_Press, 5 edges after the steady value is first sampled.
- Release aligned so the accepted fall lands on a repeat terminal count → o_Release=1, o_Repeat=0 on that edge, then IDLE.
- i_Rst for 1 cycle while held in HELD_REPEAT → all outputs 0 at the next edge, no o_Release, then o_Press again 5 edges after reset deasserts. Rerun with the macro undefined → o_Repeat stays 0 throughout.

Source files
------------

// File: rtl/switch_event_pkg.sv
// ============================================================================
// Module      : switch_event_pkg
// Description : Shared types, 25 MHz timing defaults and width helper for the
//               switch event generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package switch_event_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } rep_state_e;

  // 10 ms, 500 ms and 100 ms at 25 MHz
  localparam int unsigned DEF_DEBOUNCE_LIMIT = 250000;
  localparam int unsigned DEF_REPEAT_DELAY   = 12500000;
  localparam int unsigned DEF_REPEAT_RATE    = 2500000;

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

`default_nettype wire

// File: rtl/switch_debounce_core.sv
// ============================================================================
// Module      : switch_debounce_core
// Description : Two-flop synchroniser plus debounce counter; emits the stable
//               level and single-cycle accept strobes for rise and fall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_debounce_core
  import switch_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] LIMIT_TC = CW'(DEBOUNCE_LIMIT - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  always_comb begin
    sync1_d  = i_Switch;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    // A return to the stable value discards any partial count
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == LIMIT_TC) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      accept   = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_stable = stable_q;
  assign o_rise   = accept & sync2_q;
  assign o_fall   = accept & ~sync2_q;

endmodule

`default_nettype wire

// File: rtl/switch_event_gen.sv
// ============================================================================
// Module      : switch_event_gen
// Description : Debounced push-button front end producing press, release and
//               auto-repeat pulses. Auto-repeat is built only when the macro
//               SWITCH_AUTO_REPEAT_EN is defined; otherwise o_Repeat is 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_event_gen
  import switch_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
  parameter int unsigned REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE    = DEF_REPEAT_RATE
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Level,
  output logic o_Press,
  output logic o_Release,
  output logic o_Repeat
);

  logic stable, rise, fall;
  logic press_q, press_d;
  logic release_q, release_d;

  switch_debounce_core #(
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) u_core (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Switch(i_Switch),
    .o_stable(stable),
    .o_rise  (rise),
    .o_fall  (fall)
  );

  // Strobes are registered on the same edge the stable level flips
  always_comb begin
    press_d   = rise;
    release_d = fall;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign o_Level   = stable;
  assign o_Press   = press_q;
  assign o_Release = release_q;

`ifdef SWITCH_AUTO_REPEAT_EN
  localparam int unsigned   REP_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned   TW       = cnt_width(REP_MAX);
  localparam logic [TW-1:0] DELAY_TC = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_TC  = TW'(REPEAT_RATE - 1);

  rep_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          repeat_q, repeat_d;

  // A fall always wins over a coinciding terminal count
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    repeat_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HELD_DELAY;
          timer_d = '0;
        end
      end
      HELD_DELAY: begin
        if (fall) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == DELAY_TC) begin
          state_d  = HELD_REPEAT;
          timer_d  = '0;
          repeat_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HELD_REPEAT: begin
        if (fall) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == RATE_TC) begin
          timer_d  = '0;
          repeat_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      repeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      repeat_q <= repeat_d;
    end
  end

  assign o_Repeat = repeat_q;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
  assign o_Repeat = 1'b0;
`endif

endmodule

`default_nettype wire
